rr_bus_arbiter: RTL

RR_BUS_ARBITER -- requirements
Module: rr_bus_arbiter

---
 rtl/rr_bus_arbiter.sv | 94 +++++++++
 1 files changed

// File: rtl/rr_bus_arbiter.sv
// Two-master round-robin bus arbiter with a bounded tenure per grant.
// A one-cycle TURN gap separates every hand-over so the address/data muxes never switch under an owner.
module rr_bus_arbiter #(
    parameter int MAX_TENURE = 16,
    parameter int CNT_WIDTH  = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic m1_breq,
    input  logic m2_breq,
    output logic m1_bgnt,
    output logic m2_bgnt,
    output logic bgrant,
    output logic bus_busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        OWN_M1 = 2'd1,
        OWN_M2 = 2'd2,
        TURN   = 2'd3
    } state_t;

    localparam logic [CNT_WIDTH-1:0] MAX_CNT = CNT_WIDTH'(MAX_TENURE);
    localparam logic [CNT_WIDTH-1:0] ONE_CNT = CNT_WIDTH'(1);

    state_t               state_q;
    logic                 last_q;   // 0 = master 1 served last, 1 = master 2
    logic [CNT_WIDTH-1:0] cnt_q;

    logic any_req;
    logic pick_m2;
    logic own_req;
    logic other_req;
    logic release_d;

    // On a tie the master that was not served last wins.
    assign any_req   = m1_breq | m2_breq;
    assign pick_m2   = m2_breq & (~m1_breq | ~last_q);
    assign own_req   = (state_q == OWN_M1) ? m1_breq : m2_breq;
    assign other_req = (state_q == OWN_M1) ? m2_breq : m1_breq;
    assign release_d = ~own_req | ((cnt_q == MAX_CNT) & other_req);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            m1_bgnt  <= 1'b0;
            m2_bgnt  <= 1'b0;
            bgrant   <= 1'b0;
            bus_busy <= 1'b0;
            cnt_q    <= '0;
            last_q   <= 1'b1;
        end else begin
            case (state_q)
                IDLE, TURN: begin
                    if (any_req) begin
                        state_q  <= pick_m2 ? OWN_M2 : OWN_M1;
                        m1_bgnt  <= ~pick_m2;
                        m2_bgnt  <= pick_m2;
                        bgrant   <= pick_m2;
                        bus_busy <= 1'b1;
                        last_q   <= pick_m2;
                        cnt_q    <= ONE_CNT;
                    end else begin
                        state_q  <= IDLE;
                        m1_bgnt  <= 1'b0;
                        m2_bgnt  <= 1'b0;
                        bus_busy <= 1'b0;
                    end
                end
                OWN_M1, OWN_M2: begin
                    if (release_d) begin
                        state_q  <= TURN;
                        m1_bgnt  <= 1'b0;
                        m2_bgnt  <= 1'b0;
                        bus_busy <= 1'b0;
                    end else if (cnt_q == MAX_CNT) begin
                        // Tenure expired but nobody is waiting: keep the bus and restart the count.
                        cnt_q <= ONE_CNT;
                    end else begin
                        cnt_q <= cnt_q + ONE_CNT;
                    end
                end
                default: begin
                    state_q  <= IDLE;
                    m1_bgnt  <= 1'b0;
                    m2_bgnt  <= 1'b0;
                    bus_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule
